// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs field bundles into instruction words and streams them,
// with byte addresses, to the instruction-memory write port. Optional counters: INSTR_ENC_STATS_EN.
module instruction_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              done
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_errs
`endif
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic        last_q;
  logic        drain_last;
  logic        in_fire;
  logic        out_fire;
  logic        legal;
  logic [31:0] enc_word;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE,
      OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [6:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] f_imm
  );
    logic [31:0] w;
    w = '0;
    case (op)
      OP_R:      w = {f7, f_rs2, f_rs1, f3, f_rd, op};
      // Shift-immediates carry funct7 in the upper immediate bits and a 5-bit shamt.
      OP_IMM:    w = (f3 == 3'b001 || f3 == 3'b101)
                       ? {f7, f_imm[4:0], f_rs1, f3, f_rd, op}
                       : {f_imm[11:0], f_rs1, f3, f_rd, op};
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
                 w = {f_imm[11:0], f_rs1, f3, f_rd, op};
      OP_STORE:  w = {f_imm[11:5], f_rs2, f_rs1, f3, f_imm[4:0], op};
      OP_BRANCH: w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f3, f_imm[4:1], f_imm[11], op};
      OP_LUI, OP_AUIPC:
                 w = {f_imm[31:12], f_rd, op};
      OP_JAL:    w = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, op};
      default:   w = '0;
    endcase
    return w;
  endfunction

  assign legal    = is_legal(opcode);
  assign enc_word = encode(opcode, rd, rs1, rs2, funct3, funct7, imm);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if ((out_fire && last_q) || (drain_last && !out_valid)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state == S_STREAM) && (!out_valid || out_ready);
    done     = (state == S_DONE);
  end

  // Single-entry output register; a new word may load on the same edge the old one leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE;
      last_q     <= 1'b0;
      drain_last <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= in_fire && !legal;
      if (state == S_IDLE && start) begin
        out_addr   <= BASE;
        drain_last <= 1'b0;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        last_q    <= 1'b0;
        out_addr  <= out_addr + WORD_STEP;
      end
      if (in_fire && legal) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        last_q    <= in_last;
      end
      // A rejected final bundle still ends the program once the pending word drains.
      if (in_fire && !legal && in_last) drain_last <= 1'b1;
      if (state == S_DONE)              drain_last <= 1'b0;
    end
  end

`ifdef INSTR_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= '0;
      stat_errs  <= '0;
    end else if (state == S_IDLE && start) begin
      stat_words <= '0;
      stat_errs  <= '0;
    end else begin
      if (out_fire && stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
      if (err && stat_errs != 16'hFFFF)       stat_errs  <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder (ADDR_W=4 so address wrap is exercised often):
// directed vector table, hand-written stall/illegal/reset sequences, and a randomized scoreboard run.
module tb_instruction_encoder;

  localparam int ADDR_W = 4;
  localparam int AMOD   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [31:0]       imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic              done;

  int checks = 0;
  int errors = 0;

  instruction_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    int          addr;
  } word_t;

  logic [6:0] legal_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference encoder built from field positions with shifts and masks.
  function automatic logic [31:0] ref_encode(input logic [31:0] op, input logic [31:0] d,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] w;
    w = op;
    if (op == 32'h33)
      w |= (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (f7 << 25);
    else if (op == 32'h13 || op == 32'h03 || op == 32'h67 || op == 32'h73 || op == 32'h0F) begin
      w |= (d << 7) | (f3 << 12) | (s1 << 15) | ((im & 32'hFFF) << 20);
      if (op == 32'h13 && (f3 == 1 || f3 == 5))
        w = (w & 32'h000F_FFFF) | ((im & 32'h1F) << 20) | (f7 << 25);
    end else if (op == 32'h23)
      w |= ((im & 32'h1F) << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (((im >> 5) & 32'h7F) << 25);
    else if (op == 32'h63)
      w |= (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8) | (f3 << 12) | (s1 << 15)
         | (s2 << 20) | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 1) << 31);
    else if (op == 32'h37 || op == 32'h17)
      w |= (im & 32'hFFFF_F000) | (d << 7);
    else if (op == 32'h6F)
      w |= (d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
         | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
    else
      w = 32'h0;
    return w;
  endfunction

  task automatic drive(input vec_t v);
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check(name, {31'b0, done}, 32'd1);
  endtask

  vec_t tbl [7];
  vec_t v;
  word_t q [$];
  word_t wexp;

  initial begin
    tbl[0] = '{"addi",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h00500093};
    tbl[1] = '{"sw",    7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020A423};
    tbl[2] = '{"beq",   7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd16,        32'h00208863};
    tbl[3] = '{"jal",   7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h001000EF};
    tbl[4] = '{"srai",  7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7,         32'h40725193};
    tbl[5] = '{"lui",   7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,  32'h123452B7};
    tbl[6] = '{"add",   7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h002081B3};

    // Reset state
    #12;
    check("rst out_valid", {31'b0, out_valid}, 0);
    check("rst out_instr", out_instr, 0);
    check("rst out_addr", 32'(out_addr), 0);
    check("rst err", {31'b0, err}, 0);
    check("rst done", {31'b0, done}, 0);
    check("rst in_ready", {31'b0, in_ready}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table, back-to-back with out_ready=1; 7 words wrap the 4-bit address.
    out_ready = 1'b1;
    pulse_start();
    check("stream in_ready", {31'b0, in_ready}, 1);
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check({tbl[i-1].name, " valid"}, {31'b0, out_valid}, 1);
        check({tbl[i-1].name, " instr"}, out_instr, tbl[i-1].exp);
        check({tbl[i-1].name, " addr"}, 32'(out_addr), 32'(((i - 1) * 4) % AMOD));
        check({tbl[i-1].name, " ref"}, ref_encode(32'(tbl[i-1].op), 32'(tbl[i-1].rd),
              32'(tbl[i-1].rs1), 32'(tbl[i-1].rs2), 32'(tbl[i-1].f3), 32'(tbl[i-1].f7),
              tbl[i-1].imm), tbl[i-1].exp);
        check({tbl[i-1].name, " done"}, {31'b0, done}, 0);
      end
      if (i < 7) begin
        drive(tbl[i]); in_valid = 1'b1; in_last = (i == 6);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
    end
    @(negedge clk);
    check("table done", {31'b0, done}, 1);
    @(negedge clk);
    check("table done pulse", {31'b0, done}, 0);
    check("idle in_ready", {31'b0, in_ready}, 0);

    // JAL held under backpressure
    pulse_start();
    drive(tbl[3]); in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall valid", {31'b0, out_valid}, 1);
      check("stall instr", out_instr, 32'h001000EF);
      check("stall addr", 32'(out_addr), 0);
      check("stall in_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall release done", {31'b0, done}, 1);

    // Illegal opcode then a legal final word at the same address
    pulse_start();
    v = tbl[0]; v.op = 7'h7F; drive(v); in_valid = 1'b1;
    @(negedge clk);
    check("illegal err", {31'b0, err}, 1);
    check("illegal no valid", {31'b0, out_valid}, 0);
    check("illegal addr", 32'(out_addr), 0);
    drive(tbl[0]); in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check("after illegal err", {31'b0, err}, 0);
    check("after illegal instr", out_instr, 32'h00500093);
    check("after illegal addr", 32'(out_addr), 0);
    wait_done("after illegal done");

    // Illegal final bundle still ends the program
    pulse_start();
    v = tbl[1]; v.op = 7'h00; drive(v); in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check("illegal last err", {31'b0, err}, 1);
    wait_done("illegal last done");

    // Reset while a word is held
    @(negedge clk);
    pulse_start();
    drive(tbl[2]); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    check("pre-reset valid", {31'b0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset valid", {31'b0, out_valid}, 0);
    check("mid reset addr", 32'(out_addr), 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    pulse_start();
    drive(tbl[5]); in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check("post reset instr", out_instr, 32'h123452B7);
    check("post reset addr", 32'(out_addr), 0);
    wait_done("post reset done");

    // Randomized scoreboard run
    begin
      int  maddr = 0;
      bit  err_exp = 0;
      bit  rdy_exp;
      logic [6:0] op;
      pulse_start();
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        check("rnd out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
          check("rnd instr", out_instr, q[0].instr);
          check("rnd addr", 32'(out_addr), 32'(q[0].addr));
        end
        check("rnd err", {31'b0, err}, {31'b0, err_exp});
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          op = 7'($urandom);
          while (ref_legal(op)) op = 7'($urandom);
        end else op = legal_ops[$urandom_range(0, 10)];
        opcode = op; rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom); imm = $urandom;
        #1;
        rdy_exp = (q.size() == 0) || out_ready;
        check("rnd in_ready", {31'b0, in_ready}, {31'b0, rdy_exp});
        err_exp = 0;
        if (q.size() != 0 && out_ready) begin
          void'(q.pop_front());
          maddr = (maddr + 4) % AMOD;
        end
        if (in_valid && rdy_exp) begin
          if (ref_legal(op)) begin
            wexp.instr = ref_encode(32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(funct3),
                                    32'(funct7), imm);
            wexp.addr = maddr;
            q.push_back(wexp);
          end else err_exp = 1;
        end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      if (q.size() != 0) begin
        check("rnd drain instr", out_instr, q[0].instr);
        check("rnd drain addr", 32'(out_addr), 32'(q[0].addr));
        void'(q.pop_front());
        maddr = (maddr + 4) % AMOD;
      end
      @(negedge clk);
      drive(tbl[6]); in_valid = 1'b1; in_last = 1'b1;
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      check("rnd last instr", out_instr, 32'h002081B3);
      check("rnd last addr", 32'(out_addr), 32'(maddr));
      wait_done("rnd done");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
